// File: rtl/ex_muldiv_seq_pkg.sv
// ex_muldiv_seq_pkg
//   Shared definitions for the EX-stage multiply/divide sequencer: operation
//   encodings, FSM state encodings and the default datapath width.
package ex_muldiv_seq_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_addsub.sv
// ex_muldiv_addsub
//   W-bit adder/subtractor shared by the shift-add multiplier and the
//   restoring divider.
//   a_i, b_i : operands
//   sub_i    : 1 = a_i - b_i, 0 = a_i + b_i
//   sum_o    : W-bit result
//   cout_o   : carry out; on subtract, 1 means a_i >= b_i (no borrow)
module ex_muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
  assign {cout_o, sum_o} = full;

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX ALU. One bit per
//   cycle: shift-add multiply, restoring divide. Owns HI/LO and stalls the
//   pipeline through a start/busy/done handshake.
// Ports
//   Clk, Reset          clock (rising edge), async active-high reset
//   Start_EX, Op_EX     request and operation (sampled in IDLE/DONE only)
//   Operand_A_EX/B_EX   multiplicand/dividend, multiplier/divisor
//   Wr_HI_EX/Wr_LO_EX   MTHI/MTLO enables, Wr_Data_EX is the data
//   Busy_EX             registered, high in PREP/ITER/FIX
//   Stall_EX            combinational stall request to the pipeline
//   Done_EX             one-cycle pulse in DONE
//   Div_By_Zero_EX      with Done_EX when a divide had a zero divisor
//   HI_EX, LO_EX        HI/LO registers
//
// state | meaning
// IDLE  | waiting for Start_EX, MTHI/MTLO accepted
// PREP  | raw operands held; take magnitudes, record signs, detect B==0
// ITER  | one multiply/divide step per cycle, ITERS cycles
// FIX   | apply result signs; HI/LO loaded on the exit edge
// DONE  | Done_EX pulse; may accept a new Start_EX or MTHI/MTLO
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ITERS  = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start_EX,
  input  logic [1:0]        Op_EX,
  input  logic [DATA_W-1:0] Operand_A_EX,
  input  logic [DATA_W-1:0] Operand_B_EX,
  input  logic              Wr_HI_EX,
  input  logic              Wr_LO_EX,
  input  logic [DATA_W-1:0] Wr_Data_EX,
  output logic              Busy_EX,
  output logic              Stall_EX,
  output logic              Done_EX,
  output logic              Div_By_Zero_EX,
  output logic [DATA_W-1:0] HI_EX,
  output logic [DATA_W-1:0] LO_EX
);

  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam int AW    = DATA_W + 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic                is_div, is_signed, idle_or_done, div_zero;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [AW-1:0]       as_a, as_b, as_sum;
  logic                as_cout;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign is_div       = op_is_div(op_q);
  assign is_signed    = op_is_signed(op_q);
  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  // In PREP, acc_lo_q holds raw A and opnd_q holds raw B.
  assign div_zero     = is_div && (opnd_q == '0);
  assign mag_a        = (is_signed && acc_lo_q[DATA_W-1]) ? -acc_lo_q : acc_lo_q;
  assign mag_b        = (is_signed && opnd_q[DATA_W-1])   ? -opnd_q   : opnd_q;

  // Divide: trial subtract of the divisor from {remainder, next dividend bit}.
  // Multiply: add multiplicand to the upper product half, carry kept in bit DATA_W.
  assign as_a = is_div ? {acc_hi_q, acc_lo_q[DATA_W-1]} : {1'b0, acc_hi_q};
  assign as_b = {1'b0, opnd_q};

  ex_muldiv_addsub #(.W(AW)) u_addsub (
    .a_i    (as_a),
    .b_i    (as_b),
    .sub_i  (is_div),
    .sum_o  (as_sum),
    .cout_o (as_cout)
  );

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start_EX) state_d = PREP;
      PREP:    state_d = div_zero ? DONE : ITER;
      ITER:    if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = Start_EX ? PREP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
    done_d    = (state_d == DONE);
    dbz_d     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start_EX) begin
          op_d     = op_e'(Op_EX);
          acc_lo_d = Operand_A_EX;
          opnd_d   = Operand_B_EX;
        end else begin
          if (Wr_HI_EX) hi_d = Wr_Data_EX;
          if (Wr_LO_EX) lo_d = Wr_Data_EX;
        end
      end
      PREP: begin
        cnt_d     = '0;
        acc_hi_d  = '0;
        neg_d     = is_signed && (acc_lo_q[DATA_W-1] ^ opnd_q[DATA_W-1]);
        neg_rem_d = is_signed && acc_lo_q[DATA_W-1];
        if (div_zero) begin
          hi_d  = acc_lo_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div) begin
          acc_lo_d = mag_a;
          opnd_d   = mag_b;
        end else begin
          acc_lo_d = mag_b;
          opnd_d   = mag_a;
        end
      end
      ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div) begin
          // No borrow keeps the difference; otherwise restore the shifted remainder.
          acc_hi_d = as_cout ? as_sum[DATA_W-1:0] : as_a[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], as_cout};
        end else if (acc_lo_q[0]) begin
          acc_hi_d = as_sum[DATA_W:1];
          acc_lo_d = {as_sum[0], acc_lo_q[DATA_W-1:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[DATA_W-1:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[DATA_W-1:1]};
        end
      end
      FIX: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q      <= OP_MULTU;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy_EX        = busy_q;
  assign Stall_EX       = busy_q | (Start_EX & idle_or_done);
  assign Done_EX        = done_q;
  assign Div_By_Zero_EX = dbz_q;
  assign HI_EX          = hi_q;
  assign LO_EX          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start_EX = 1'b0;
  logic [1:0]  Op_EX = 2'b00;
  logic [31:0] Operand_A_EX = '0;
  logic [31:0] Operand_B_EX = '0;
  logic        Wr_HI_EX = 1'b0;
  logic        Wr_LO_EX = 1'b0;
  logic [31:0] Wr_Data_EX = '0;
  logic        Busy_EX, Stall_EX, Done_EX, Div_By_Zero_EX;
  logic [31:0] HI_EX, LO_EX;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  ex_muldiv_seq dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Start_EX       (Start_EX),
    .Op_EX          (Op_EX),
    .Operand_A_EX   (Operand_A_EX),
    .Operand_B_EX   (Operand_B_EX),
    .Wr_HI_EX       (Wr_HI_EX),
    .Wr_LO_EX       (Wr_LO_EX),
    .Wr_Data_EX     (Wr_Data_EX),
    .Busy_EX        (Busy_EX),
    .Stall_EX       (Stall_EX),
    .Done_EX        (Done_EX),
    .Div_By_Zero_EX (Div_By_Zero_EX),
    .HI_EX          (HI_EX),
    .LO_EX          (LO_EX)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    logic [63:0] up;
    longint      sa, sb, sp, q, r;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      2'b01: begin sp = sa * sb; {hi, lo} = sp; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 2'b10) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endfunction

  // Timeline model: an op accepted at edge T enters DONE at edge T+34
  // (T+1 on divide-by-zero); Busy is high after edges T..D-1.
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  bit          m_busy, m_done, m_dbz, m_pend, r_dbz;
  int          m_edge, m_D;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dbz = 0; m_pend = 0; m_edge = 0;
    end else begin : step
      bit was_busy;
      was_busy = m_busy;
      m_edge++;
      m_done = 0;
      m_dbz  = 0;
      if (m_pend && m_edge == m_D) begin
        m_hi = r_hi; m_lo = r_lo; m_done = 1; m_dbz = r_dbz; m_pend = 0;
      end
      if (!was_busy) begin
        if (Start_EX) begin
          ref_op(Op_EX, Operand_A_EX, Operand_B_EX, r_hi, r_lo, r_dbz);
          m_D    = m_edge + (r_dbz ? 1 : 34);
          m_pend = 1;
        end else begin
          if (Wr_HI_EX) m_hi = Wr_Data_EX;
          if (Wr_LO_EX) m_lo = Wr_Data_EX;
        end
      end
      m_busy = m_pend && (m_edge < m_D);
    end
  end

  always @(negedge Clk) begin
    chk("busy",  Busy_EX, m_busy);
    chk("done",  Done_EX, m_done);
    chk("dbz",   Div_By_Zero_EX, m_dbz);
    chk("hi",    HI_EX, m_hi);
    chk("lo",    LO_EX, m_lo);
    chk("stall", Stall_EX, m_busy | (Start_EX & ~m_busy));
  end

  task automatic sync();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    sync();
    Start_EX = 1'b1; Op_EX = op; Operand_A_EX = a; Operand_B_EX = b;
    sync();
    Start_EX = 1'b0; Op_EX = 2'($urandom); Operand_A_EX = $urandom; Operand_B_EX = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge Clk);
      n++;
      seen = Done_EX;
    end
    if (!seen) chk({name, " done timeout"}, 64'd0, 64'd1);
    else       chk({name, " latency"}, 64'(n), 64'(exp_lat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    chk("reset hi", HI_EX, 0);
    chk("reset lo", LO_EX, 0);
    chk("reset busy", Busy_EX, 0);
    chk("reset done", Done_EX, 0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(35, "multu max");
    chk("multu max hi", HI_EX, 32'hFFFF_FFFE);
    chk("multu max lo", LO_EX, 32'h0000_0001);

    issue(2'b01, 32'hFFFF_FFF9, 32'd3);
    wait_done(35, "mult -7*3");
    chk("mult -7*3 hi", HI_EX, 32'hFFFF_FFFF);
    chk("mult -7*3 lo", LO_EX, 32'hFFFF_FFEB);

    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(35, "div -7/2");
    chk("div -7/2 lo", LO_EX, 32'hFFFF_FFFD);
    chk("div -7/2 hi", HI_EX, 32'hFFFF_FFFF);

    issue(2'b10, 32'h0000_1234, 32'd0);
    wait_done(2, "divu by0");
    chk("divu by0 dbz", Div_By_Zero_EX, 1);
    chk("divu by0 lo", LO_EX, 32'hFFFF_FFFF);
    chk("divu by0 hi", HI_EX, 32'h0000_1234);

    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(35, "div min/-1");
    chk("div min/-1 lo", LO_EX, 32'h8000_0000);
    chk("div min/-1 hi", HI_EX, 32'h0);
    chk("div min/-1 dbz", Div_By_Zero_EX, 0);

    // Start while busy is ignored.
    issue(2'b00, 32'd3, 32'd5);
    repeat (9) sync();
    Start_EX = 1'b1; Op_EX = 2'b10; Operand_A_EX = 32'd9; Operand_B_EX = 32'd0;
    sync();
    Start_EX = 1'b0;
    wait_done(25, "multu 3*5");
    chk("multu 3*5 lo", LO_EX, 32'd15);
    chk("multu 3*5 hi", HI_EX, 32'd0);

    // Reset mid-operation aborts.
    issue(2'b00, 32'd3, 32'd5);
    repeat (19) sync();
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort busy", Busy_EX, 0);
    chk("abort hi", HI_EX, 0);
    chk("abort lo", LO_EX, 0);
    sync();
    Reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge Clk);
      dones += int'(Done_EX);
    end
    chk("abort no done", 64'(dones), 64'd0);

    // MTHI in IDLE, then during Busy, then Start+MTLO together.
    sync();
    Wr_HI_EX = 1'b1; Wr_Data_EX = 32'hA5A5_A5A5;
    sync();
    Wr_HI_EX = 1'b0;
    @(negedge Clk);
    chk("mthi idle", HI_EX, 32'hA5A5_A5A5);

    issue(2'b00, 32'd2, 32'd3);
    repeat (3) sync();
    Wr_HI_EX = 1'b1; Wr_Data_EX = 32'h0000_1111;
    sync();
    Wr_HI_EX = 1'b0;
    wait_done(31, "mthi busy");
    chk("mthi busy hi", HI_EX, 32'd0);
    chk("mthi busy lo", LO_EX, 32'd6);

    sync();
    Start_EX = 1'b1; Op_EX = 2'b10; Operand_A_EX = 32'd100; Operand_B_EX = 32'd7;
    Wr_LO_EX = 1'b1; Wr_Data_EX = 32'h0000_DEAD;
    sync();
    Start_EX = 1'b0; Wr_LO_EX = 1'b0;
    wait_done(35, "start+mtlo");
    chk("start+mtlo lo", LO_EX, 32'd14);
    chk("start+mtlo hi", HI_EX, 32'd2);

    issue(2'b11, 32'hFFFF_FF00, 32'd0);
    wait_done(2, "div neg by0");
    chk("div neg by0 hi", HI_EX, 32'hFFFF_FF00);

    // Random traffic; the model compare covers every cycle.
    for (int i = 0; i < 6000; i++) begin
      sync();
      Start_EX     = ($urandom_range(0, 7) == 0);
      Op_EX        = 2'($urandom);
      Operand_A_EX = pick();
      Operand_B_EX = pick();
      Wr_HI_EX     = ($urandom_range(0, 9) == 0);
      Wr_LO_EX     = ($urandom_range(0, 9) == 0);
      Wr_Data_EX   = $urandom;
      Reset        = ($urandom_range(0, 999) == 0);
    end
    sync();
    Reset = 1'b0; Start_EX = 1'b0; Wr_HI_EX = 1'b0; Wr_LO_EX = 1'b0;
    repeat (40) sync();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
